vm_param_ctrl: RTL and testbench
================================

Name: vm_param_ctrl

Overview:
Parametrised vending-machine controller, successor to the fixed two-coin vending FSM. Accepts coin codes on D_in and accumulates credit against a configurable PRICE. Issues a one-cycle dispense pulse, then pays change as a countable pulse train. Adds cancel/refund, coin rejection while busy, and single-count of held coin codes. Sits between the coin-acceptor input logic and the dispense/change actuators.

Parameters:
PRICE, 5, item price in credit units (1 unit = 0.5 yuan); must be >= 1
VAL_A, 1, credit value of coin code 2'b01
VAL_B, 2, credit value of coin code 2'b10
CREDIT_W, 4, width of the credit and change counters; requires PRICE+VAL_B-1 < 2**CREDIT_W

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
D_in  in  2  coin code: 00 none, 01 coin A, 10 coin B, 11 cancel/refund request
D_out  out  1  dispense pulse, high exactly 1 cycle per vend
D_C  out  1  change pulse; one high cycle per credit unit returned
Credit  out  CREDIT_W  current accumulated credit
Busy  out  1  high in VEND and CHANGE states
Coin_rej  out  1  1-cycle pulse when a coin event arrives while Busy

Behaviour:
- Reset (sampled on Clk edge) sets state=ACCUM, Credit=0, remaining change=0, D_out=0, D_C=0, Busy=0, Coin_rej=0, and prev-code register=00. Reset has priority over all events, including mid-VEND and mid-CHANGE; pending change is discarded.
- Event detection: an event fires in the cycle after D_in changes from 00 to a nonzero code. D_in held nonzero for N cycles yields exactly one event. A direct nonzero-to-different-nonzero transition is not an event; D_in must return to 00 first.
- All outputs are registered; one-cycle latency from event to effect.
- ACCUM state:
  - Coin event with value v and sum = Credit+v < PRICE: Credit <= sum.
  - Coin event with sum >= PRICE: Credit <= 0, remaining <= sum-PRICE, go to VEND.
  - Cancel event with Credit > 0: remaining <= Credit, Credit <= 0, go to CHANGE. No D_out.
  - Cancel event with Credit = 0: ignored.
- VEND state (1 cycle): D_out=1. Next state is CHANGE if remaining > 0, else ACCUM.
- CHANGE state uses sub-phases PULSE and GAP.
  - PULSE: D_C=1 and remaining decrements.
  - GAP: D_C=0.
  - After the GAP that follows the last unit, go to ACCUM.
  - N units produce N pulses, each separated by one low cycle.
- Busy: any event (coin or cancel) during VEND or CHANGE is dropped.
  - A coin event also pulses Coin_rej for 1 cycle.
  - Credit and remaining are unaffected.
  - Cancel while Busy is ignored silently.
- Credit never exceeds PRICE-1 in ACCUM. Remaining never exceeds max(VAL_B-1, PRICE-1).

Decomposition:
- Shared package vm_pkg: coin code constants (COIN_NONE, COIN_A, COIN_B, COIN_CANCEL) and the state enum (ST_ACCUM, ST_VEND, ST_CHANGE).
- One sub-module: vm_coin_edge, containing the prev-code register and event/code outputs, reusable by other acceptor front-ends.
- Credit arithmetic, FSM and change sequencer stay in vm_param_ctrl.

Test Plan:
- Defaults. Reset, then events 01, 10, 10 (each held 2 cycles, 00 between) -> Credit 1, then 3, then D_out pulse 1 cycle; Credit=0; no D_C.
- Events 10, 10, 10 -> Credit 2, 4, then D_out; then exactly 1 D_C pulse; Busy high 3 cycles; return to ACCUM with Credit=0.
- Events 01, 10, then 11 -> Credit 3; then 3 D_C pulses separated by 1 low cycle; D_out never asserted.
- Hold D_in=01 for 5 cycles -> Credit=1 only. Toggle 01 directly to 10 without 00 -> no extra event.
- Coin 10 issued during CHANGE -> Coin_rej 1-cycle pulse; Credit stays 0; change pulse count unchanged.
- Assert Reset in the second cycle of CHANGE -> next edge: D_C=0, Busy=0, Credit=0; no further D_C pulses. Separately, with PRICE=7, VAL_B=4: events 10, 10, 10 -> vend with 1 D_C pulse.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine controller family: coin codes,
// controller states and small coin-decoding helpers.
package vm_pkg;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_A      = 2'b01;
    localparam logic [1:0] COIN_B      = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    // Change is paid as alternating high/low cycles on the change output.
    typedef enum logic {
        PH_PULSE = 1'b0,
        PH_GAP   = 1'b1
    } chg_phase_e;

    function automatic int coin_value(input logic [1:0] code,
                                      input int         val_a,
                                      input int         val_b);
        case (code)
            COIN_A:  return val_a;
            COIN_B:  return val_b;
            default: return 0;
        endcase
    endfunction

    function automatic logic is_coin(input logic [1:0] code);
        return (code == COIN_A) || (code == COIN_B);
    endfunction

endpackage

// File: rtl/vm_coin_edge.sv
// Coin-acceptor front end: turns a held coin code into a single event that
// fires only when the code rises from idle (00) to a nonzero value.
module vm_coin_edge
    import vm_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] D_in,
    output logic       coin_evt,
    output logic [1:0] coin_code
);

    logic [1:0] prev_code;

    // NOTE: prev_code is clocked state, so it takes a non-blocking assignment;
    // a blocking one here would let the compare below see this cycle's value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_code <= COIN_NONE;
        end else begin
            prev_code <= D_in;
        end
    end

    // A nonzero-to-different-nonzero change is deliberately not an event.
    assign coin_evt  = (prev_code == COIN_NONE) && (D_in != COIN_NONE);
    assign coin_code = D_in;

endmodule

// File: rtl/vm_param_ctrl.sv
// Parametrised vending controller: accumulates coin credit against PRICE,
// pulses a dispense output, then pays change as a countable pulse train.
module vm_param_ctrl
    import vm_pkg::*;
#(
    parameter int PRICE    = 5,
    parameter int VAL_A    = 1,
    parameter int VAL_B    = 2,
    parameter int CREDIT_W = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          D_in,
    output logic                D_out,
    output logic                D_C,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Busy,
    output logic                Coin_rej
);

    // One extra bit so credit plus the largest coin can never wrap.
    localparam int                SUM_W   = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]  PRICE_S = SUM_W'(PRICE);

    logic                coin_evt;
    logic [1:0]          coin_code;
    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    sum;
    logic                sum_vends;

    state_e              state;
    chg_phase_e          phase;
    logic [CREDIT_W-1:0] remaining;

    vm_coin_edge u_coin_edge (
        .Clk       (Clk),
        .Reset     (Reset),
        .D_in      (D_in),
        .coin_evt  (coin_evt),
        .coin_code (coin_code)
    );

    assign coin_val  = SUM_W'(coin_value(coin_code, VAL_A, VAL_B));
    assign sum       = {1'b0, Credit} + coin_val;
    assign sum_vends = (sum >= PRICE_S);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_ACCUM;
            phase     <= PH_PULSE;
            Credit    <= '0;
            remaining <= '0;
            D_out     <= 1'b0;
            D_C       <= 1'b0;
            Busy      <= 1'b0;
            Coin_rej  <= 1'b0;
        end else begin
            // Pulse outputs fall by default and are raised only on the
            // transitions that need them.
            D_out    <= 1'b0;
            D_C      <= 1'b0;
            Coin_rej <= coin_evt && is_coin(coin_code) && (state != ST_ACCUM);

            case (state)
                ST_ACCUM: begin
                    if (coin_evt && is_coin(coin_code)) begin
                        if (sum_vends) begin
                            Credit    <= '0;
                            remaining <= CREDIT_W'(sum - PRICE_S);
                            state     <= ST_VEND;
                            D_out     <= 1'b1;
                            Busy      <= 1'b1;
                        end else begin
                            Credit <= CREDIT_W'(sum);
                        end
                    end else if (coin_evt && (Credit != '0)) begin
                        // Refund: the whole credit is returned as change.
                        remaining <= Credit;
                        Credit    <= '0;
                        state     <= ST_CHANGE;
                        phase     <= PH_PULSE;
                        D_C       <= 1'b1;
                        Busy      <= 1'b1;
                    end
                end

                ST_VEND: begin
                    if (remaining != '0) begin
                        state <= ST_CHANGE;
                        phase <= PH_PULSE;
                        D_C   <= 1'b1;
                    end else begin
                        state <= ST_ACCUM;
                        Busy  <= 1'b0;
                    end
                end

                ST_CHANGE: begin
                    if (phase == PH_PULSE) begin
                        phase     <= PH_GAP;
                        remaining <= remaining - 1'b1;
                    end else if (remaining != '0) begin
                        phase <= PH_PULSE;
                        D_C   <= 1'b1;
                    end else begin
                        state <= ST_ACCUM;
                        Busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_ACCUM;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_param_ctrl.sv
// Scoreboard bench: two controller configurations share one stimulus stream;
// a pattern-list model predicts every cycle with visible activity.
module tb_vm_param_ctrl;
    import vm_pkg::*;

    localparam int NDUT = 2;

    typedef struct packed {
        logic [15:0] edge_n;
        logic        dout;
        logic        dc;
        logic        bsy;
        logic        rej;
        logic [3:0]  cred;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       d_in;
    logic [1:0]       d_out, d_c, busy, coin_rej;
    logic [1:0][3:0]  credit;

    always #5 clk = ~clk;

    vm_param_ctrl #(.PRICE(5), .VAL_A(1), .VAL_B(2), .CREDIT_W(4)) u_dut_def (
        .Clk(clk), .Reset(rst), .D_in(d_in), .D_out(d_out[0]), .D_C(d_c[0]),
        .Credit(credit[0]), .Busy(busy[0]), .Coin_rej(coin_rej[0])
    );

    vm_param_ctrl #(.PRICE(7), .VAL_A(1), .VAL_B(4), .CREDIT_W(4)) u_dut_p7 (
        .Clk(clk), .Reset(rst), .D_in(d_in), .D_out(d_out[1]), .D_C(d_c[1]),
        .Credit(credit[1]), .Busy(busy[1]), .Coin_rej(coin_rej[1])
    );

    function automatic int price_of(input int i);
        return (i == 0) ? 5 : 7;
    endfunction

    function automatic int val_b_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    int         pos_cnt = 0;
    int         checks  = 0;
    int         errors  = 0;
    bit         mon_en  = 1'b0;

    obs_t       exp_q   [NDUT][$];
    int         m_credit[NDUT];
    logic [1:0] m_prev  [NDUT];
    logic [1:0] m_pat   [NDUT][$];   // {dout,dc} for each upcoming busy cycle
    logic       m_busy  [NDUT];
    obs_t       m_last  [NDUT];
    obs_t       mon_last[NDUT];
    obs_t       mon_o;
    obs_t       mon_x;

    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Predict the outputs that follow clock edge e for configuration i.
    task automatic model_step(input int i, input logic r, input logic [1:0] c, input int e);
        obs_t       o   = '0;
        logic [1:0] cur = 2'b00;
        logic       ev;
        int         s;
        o.edge_n = 16'(e);
        if (r) begin
            m_credit[i] = 0;
            m_prev[i]   = 2'b00;
            m_pat[i].delete();
            m_busy[i]   = 1'b0;
        end else begin
            ev        = (m_prev[i] == 2'b00) && (c != 2'b00);
            m_prev[i] = c;
            if (ev && m_busy[i]) begin
                o.rej = (c != COIN_CANCEL);
            end else if (ev && c != COIN_CANCEL) begin
                s = m_credit[i] + ((c == COIN_A) ? 1 : val_b_of(i));
                if (s < price_of(i)) begin
                    m_credit[i] = s;
                end else begin
                    m_credit[i] = 0;
                    m_pat[i].push_back(2'b10);
                    for (int k = 0; k < s - price_of(i); k++) begin
                        m_pat[i].push_back(2'b01);
                        m_pat[i].push_back(2'b00);
                    end
                end
            end else if (ev && m_credit[i] > 0) begin
                for (int k = 0; k < m_credit[i]; k++) begin
                    m_pat[i].push_back(2'b01);
                    m_pat[i].push_back(2'b00);
                end
                m_credit[i] = 0;
            end
            if (m_pat[i].size() > 0) begin
                cur      = m_pat[i].pop_front();
                m_busy[i] = 1'b1;
            end else begin
                m_busy[i] = 1'b0;
            end
        end
        o.dout = cur[1];
        o.dc   = cur[0];
        o.bsy  = m_busy[i];
        o.cred = 4'(m_credit[i]);
        if (o.dout || o.dc || o.rej || o.cred != m_last[i].cred || o.bsy != m_last[i].bsy)
            exp_q[i].push_back(o);
        m_last[i] = o;
    endtask

    task automatic apply(input logic r, input logic [1:0] c);
        rst  = r;
        d_in = c;
        for (int i = 0; i < NDUT; i++) model_step(i, r, c, pos_cnt + 1);
    endtask

    task automatic tick(input logic r, input logic [1:0] c);
        @(negedge clk);
        apply(r, c);
    endtask

    task automatic coin(input logic [1:0] c, input int hold);
        repeat (hold) tick(1'b0, c);
        tick(1'b0, COIN_NONE);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, COIN_NONE);
    endtask

    // Monitor: any cycle with visible activity must match the next prediction.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NDUT; i++) begin
                mon_o.edge_n = 16'(pos_cnt);
                mon_o.dout   = d_out[i];
                mon_o.dc     = d_c[i];
                mon_o.bsy    = busy[i];
                mon_o.rej    = coin_rej[i];
                mon_o.cred   = credit[i];
                if (mon_o.dout || mon_o.dc || mon_o.rej ||
                    mon_o.cred != mon_last[i].cred || mon_o.bsy != mon_last[i].bsy) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected activity: got %h expected none", i, mon_o);
                    end else begin
                        mon_x = exp_q[i].pop_front();
                        check($sformatf("dut%0d edge %0d outputs", i, mon_x.edge_n),
                              32'(mon_o), 32'(mon_x));
                    end
                end
                mon_last[i] = mon_o;
            end
        end
    end

    int         r_sel;
    int         hold;
    logic [1:0] code;

    initial begin
        rst  = 1'b1;
        d_in = COIN_NONE;
        for (int i = 0; i < NDUT; i++) begin
            m_credit[i] = 0;
            m_prev[i]   = 2'b00;
            m_busy[i]   = 1'b0;
            m_last[i]   = '0;
            mon_last[i] = '0;
        end

        tick(1'b1, COIN_NONE);
        tick(1'b1, COIN_NONE);
        @(negedge clk);
        check("reset state", 32'({d_out, d_c, busy, coin_rej, credit}), 32'd0);
        apply(1'b0, COIN_NONE);
        mon_en = 1'b1;

        // Exact vend from coins A, B, B.
        coin(COIN_A, 2); coin(COIN_B, 2); coin(COIN_B, 2); idle(8);
        // Vend with change: B, B, B.
        coin(COIN_B, 2); coin(COIN_B, 2); coin(COIN_B, 2); idle(8);
        // Refund of accumulated credit.
        coin(COIN_A, 2); coin(COIN_B, 2); coin(COIN_CANCEL, 2); idle(10);
        // Held code counts once; a direct code swap is not a new event.
        coin(COIN_A, 5);
        tick(1'b0, COIN_A); tick(1'b0, COIN_B); tick(1'b0, COIN_NONE);
        coin(COIN_CANCEL, 1); idle(8);
        // Coin arriving during change is rejected.
        coin(COIN_A, 1); coin(COIN_B, 1); coin(COIN_CANCEL, 1);
        coin(COIN_B, 1); idle(10);
        // Reset in the second cycle of change.
        coin(COIN_A, 1); coin(COIN_B, 1);
        tick(1'b0, COIN_CANCEL); tick(1'b0, COIN_NONE); tick(1'b1, COIN_NONE);
        idle(8);

        for (int n = 0; n < 250; n++) begin
            r_sel = $urandom_range(0, 99);
            if (r_sel < 3) begin
                tick(1'b1, COIN_NONE);
            end else begin
                code = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 3);
                repeat (hold) tick(1'b0, code);
                repeat ($urandom_range(0, 4)) tick(1'b0, COIN_NONE);
            end
        end

        idle(20);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("dut%0d pending expectations", i), 32'(exp_q[i].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
